// File: rtl/bit4_addsub_pkg.sv
// bit4_addsub_pkg
// Shared constants and types for the 4-bit adder/subtractor and its users
// (e.g. the BCD adder stage).
//   WIDTH    : operand width, fixed at 4
//   MODE_ADD : cin value selecting a + b
//   MODE_SUB : cin value selecting a - b
//   nibble_t : 4-bit operand/result type
package bit4_addsub_pkg;

   localparam int unsigned WIDTH = 4;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   typedef logic [WIDTH-1:0] nibble_t;

   // Conditions operand B for the ripple core: inverting B and feeding cin = 1 into bit 0
   // forms a + ~b + 1, i.e. two's complement subtraction.
   function automatic nibble_t condition_b(input nibble_t b, input logic mode);
      nibble_t bx;
      bx = (mode == MODE_SUB) ? ~b : b;
      return bx;
   endfunction

endpackage

// File: rtl/full_adder.sv
// full_adder
// Single-bit full adder, the ripple element of bit4_adder_sub.
// Ports:
//   a, b : addend bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out (majority of a, b, ci)
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/bit4_adder_sub.sv
// bit4_adder_sub
// Registered 4-bit ripple-carry adder/subtractor. cin = 0 adds, cin = 1 subtracts
// (a + ~b + 1). Results load into output registers one clock after valid operands.
// Ports:
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset, clears all outputs
//   in_valid  : a/b/cin valid this cycle; outputs hold when low
//   a, b      : 4-bit operands
//   cin       : mode select and carry-in (0 = add, 1 = subtract)
//   sum       : registered result, modulo 16
//   cout      : registered carry out of bit 3 (in subtract mode 1 = no borrow)
//   out_valid : in_valid delayed by one clock
//   ovf       : registered signed overflow, present only with BIT4_ADDSUB_OVF_EN
// Configuration macro: BIT4_ADDSUB_OVF_EN adds the ovf port and register.
module bit4_adder_sub
   import bit4_addsub_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
`ifdef BIT4_ADDSUB_OVF_EN
   output logic             ovf,
`endif
   output logic             out_valid
);

   // ---------------------------------------------------------------------------------------
   // Combinational core
   // ---------------------------------------------------------------------------------------
   nibble_t          bx;
   nibble_t          core_sum;
   logic [WIDTH:0]   carry;

   assign bx       = condition_b(b, cin);
   assign carry[0] = cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
      full_adder u_fa (
         .a  (a[i]),
         .b  (bx[i]),
         .ci (carry[i]),
         .s  (core_sum[i]),
         .co (carry[i+1])
      );
   end

   // ---------------------------------------------------------------------------------------
   // Output registers
   // ---------------------------------------------------------------------------------------
   nibble_t sum_d, sum_q;
   logic    cout_d, cout_q;
   logic    out_valid_d, out_valid_q;

   always_comb begin
      sum_d       = sum_q;
      cout_d      = cout_q;
      out_valid_d = in_valid;
      if (in_valid) begin
         sum_d  = core_sum;
         cout_d = carry[WIDTH];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_q       <= '0;
         cout_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         sum_q       <= sum_d;
         cout_q      <= cout_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign sum       = sum_q;
   assign cout      = cout_q;
   assign out_valid = out_valid_q;

`ifdef BIT4_ADDSUB_OVF_EN
   // Signed overflow: carry into the sign bit differs from carry out of it.
   logic ovf_d, ovf_q;

   always_comb begin
      ovf_d = ovf_q;
      if (in_valid) begin
         ovf_d = carry[WIDTH-1] ^ carry[WIDTH];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_bit4_adder_sub.sv
// tb_bit4_adder_sub
// Self-checking bench for bit4_adder_sub: directed cases followed by random operations
// compared against an arithmetic reference model. Honours BIT4_ADDSUB_OVF_EN.
module tb_bit4_adder_sub;
   import bit4_addsub_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       in_valid = 1'b0;
   logic [3:0] a = '0;
   logic [3:0] b = '0;
   logic       cin = 1'b0;
   logic [3:0] sum;
   logic       cout;
   logic       out_valid;
`ifdef BIT4_ADDSUB_OVF_EN
   logic       ovf;
`endif

   int checks   = 0;
   int failures = 0;

   // Reference model state: last loaded result.
   logic [3:0] exp_sum   = '0;
   logic       exp_cout  = 1'b0;
   logic       exp_ovf   = 1'b0;
   logic       exp_valid = 1'b0;

   bit4_adder_sub u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sum       (sum),
      .cout      (cout),
`ifdef BIT4_ADDSUB_OVF_EN
      .ovf       (ovf),
`endif
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Plain-arithmetic model of one operation.
   task automatic model(input logic [3:0] ma, input logic [3:0] mb, input logic mcin);
      int ua, ub, sa, sb, sres;
      ua = int'(ma);
      ub = int'(mb);
      sa = (ua > 7) ? ua - 16 : ua;
      sb = (ub > 7) ? ub - 16 : ub;
      if (mcin == MODE_SUB) begin
         exp_sum  = 4'((ua - ub) & 15);
         exp_cout = (ua >= ub);
         sres     = sa - sb;
      end else begin
         exp_sum  = 4'((ua + ub) & 15);
         exp_cout = (ua + ub) > 15;
         sres     = sa + sb;
      end
      exp_ovf = (sres < -8) || (sres > 7);
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".sum"}, int'(sum), int'(exp_sum));
      check({tag, ".cout"}, int'(cout), int'(exp_cout));
      check({tag, ".valid"}, int'(out_valid), int'(exp_valid));
`ifdef BIT4_ADDSUB_OVF_EN
      check({tag, ".ovf"}, int'(ovf), int'(exp_ovf));
`endif
   endtask

   // Drive one cycle at the falling edge, sample 1 time unit after the next rising edge.
   task automatic step(input logic v, input logic [3:0] sa, input logic [3:0] sb,
                       input logic sc, input string tag);
      @(negedge clk);
      in_valid = v;
      a        = sa;
      b        = sb;
      cin      = sc;
      if (v) model(sa, sb, sc);
      exp_valid = v;
      @(posedge clk);
      #1;
      check_outputs(tag);
   endtask

   // Directed case with independent fixed expectations for sum/cout.
   task automatic directed(input logic [3:0] sa, input logic [3:0] sb, input logic sc,
                           input logic [3:0] want_sum, input logic want_cout,
                           input string tag);
      step(1'b1, sa, sb, sc, tag);
      check({tag, ".fixed_sum"}, int'(sum), int'(want_sum));
      check({tag, ".fixed_cout"}, int'(cout), int'(want_cout));
   endtask

   initial begin
      // Power-on reset.
      rst = 1'b1;
      #12;
      check_outputs("reset0");
      @(negedge clk);
      rst = 1'b0;

      // Load a nonzero result, then assert reset between edges.
      directed(4'b1010, 4'b0111, MODE_ADD, 4'b0001, 1'b1, "pre_rst");
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      exp_sum = '0; exp_cout = 1'b0; exp_ovf = 1'b0; exp_valid = 1'b0;
      check_outputs("async_rst");
      // Operation presented during reset is discarded.
      in_valid = 1'b1;
      a = 4'hF; b = 4'hF; cin = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check_outputs("post_rel0");
      step(1'b0, 4'h3, 4'h4, MODE_ADD, "post_rel1");

      // Directed arithmetic.
      directed(4'b1010, 4'b0011, MODE_ADD, 4'b1101, 1'b0, "add_nc");
      directed(4'b1010, 4'b0000, MODE_ADD, 4'b1010, 1'b0, "add_zero");
      directed(4'b1010, 4'b0111, MODE_ADD, 4'b0001, 1'b1, "add_c1");
      directed(4'b1010, 4'b1000, MODE_ADD, 4'b0010, 1'b1, "add_c2");
      directed(4'b1010, 4'b0011, MODE_SUB, 4'b0111, 1'b1, "sub_nb");
      directed(4'b0011, 4'b1010, MODE_SUB, 4'b1001, 1'b0, "sub_b");
      directed(4'b1100, 4'b0110, MODE_ADD, 4'b0010, 1'b1, "bcd_corr");

      // Overflow cases and hold.
      directed(4'b0111, 4'b0001, MODE_ADD, 4'b1000, 1'b0, "ovf_pos");
`ifdef BIT4_ADDSUB_OVF_EN
      check("ovf_pos.fixed", int'(ovf), 1);
`endif
      step(1'b0, 4'h0, 4'h0, MODE_ADD, "hold0");
      check("hold0.fixed_sum", int'(sum), 8);
      directed(4'b1000, 4'b0001, MODE_SUB, 4'b0111, 1'b1, "ovf_neg");
`ifdef BIT4_ADDSUB_OVF_EN
      check("ovf_neg.fixed", int'(ovf), 1);
`endif
      directed(4'b0010, 4'b0011, MODE_ADD, 4'b0101, 1'b0, "no_ovf");
`ifdef BIT4_ADDSUB_OVF_EN
      check("no_ovf.fixed", int'(ovf), 0);
`endif
      step(1'b0, 4'hF, 4'hE, MODE_SUB, "hold1");
      step(1'b0, 4'h9, 4'h1, MODE_ADD, "hold2");

      // Random traffic, roughly 3/4 valid, including back-to-back.
      for (int i = 0; i < 300; i++) begin
         step($urandom_range(3, 0) != 0, 4'($urandom), 4'($urandom), 1'($urandom),
              "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global time limit so the run always ends.
   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
